// File: rtl/boa_stage_if_queue.sv
// Instruction fetch stage with a small circular fetch queue in front of decode.
// One memory request in flight at a time; predict/correct redirects flush the queue.
module boa_stage_if_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [29:0] RESET_VEC = 30'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,

  output logic        o_mem_re,
  output logic [29:0] o_mem_addr,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,

  output logic        o_q_valid,
  output logic [29:0] o_q_pc,
  output logic [31:0] o_q_insn,

  input  logic        i_stall,
  input  logic        i_predict,
  input  logic [29:0] i_predict_target,
  input  logic        i_correct,
  input  logic [29:0] i_correct_alt
);

  // DEPTH must be a power of two (2, 4, 8 or 16) so the pointers wrap naturally.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [29:0] r_fetch_pc;
  ptr_t        r_head;
  ptr_t        r_tail;
  cnt_t        r_count;
  logic        r_inflight;
  logic [29:0] r_inflight_pc;
  logic        r_discard;

  logic [29:0] r_pc_mem   [DEPTH];
  logic [31:0] r_insn_mem [DEPTH];

  logic        w_redirect;
  logic [29:0] w_redirect_pc;
  cnt_t        w_occupancy;
  logic        w_mem_re;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  // Reserve a queue slot for every outstanding request so a response can never overflow.
  assign w_redirect    = i_predict | i_correct;
  assign w_redirect_pc = i_correct ? i_correct_alt : i_predict_target;
  assign w_occupancy   = r_count + cnt_t'(r_inflight);
  assign w_mem_re      = rst_n & ~w_redirect & (w_occupancy < DEPTH_C);
  assign w_accept      = w_mem_re & i_mem_ready;
  assign w_push        = r_inflight & ~r_discard & ~w_redirect;
  assign w_pop         = o_q_valid & ~i_stall & ~w_redirect;

  assign o_mem_re   = w_mem_re;
  assign o_mem_addr = r_fetch_pc;
  assign o_q_valid  = (r_count != '0);
  assign o_q_pc     = r_pc_mem[r_head];
  assign o_q_insn   = r_insn_mem[r_head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_VEC;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_discard     <= 1'b0;
    end else begin
      // A redirect landing on a response cycle drops that word; the flag covers its aftermath.
      r_discard <= w_redirect & r_inflight;
      if (w_redirect) begin
        r_fetch_pc <= w_redirect_pc;
        r_head     <= r_tail;
        r_count    <= '0;
        r_inflight <= 1'b0;
      end else begin
        if (w_accept) begin
          r_fetch_pc    <= r_fetch_pc + 30'd1;
          r_inflight_pc <= r_fetch_pc;
        end
        r_inflight <= w_accept;
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]   <= r_inflight_pc;
      r_insn_mem[r_tail] <= i_mem_rdata;
    end
  end

endmodule

// File: doc/boa_stage_if_queue.md
BOA_STAGE_IF_QUEUE -- requirements
Module: boa_stage_if_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the fetch queue entry count; legal values are 2, 4, 8 and 16.
REQ-002 Parameter RESET_VEC, default 30'h0000_0000, SHALL set the word-address fetch PC after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 mem_re  output  1  SHALL be the instruction read request.
REQ-006 mem_addr  output  30  SHALL be the word address [31:2] of the request.
REQ-007 mem_ready  input  1  SHALL indicate that the memory accepts the request this cycle.
REQ-008 mem_rdata  input  32  SHALL carry read data for the request accepted in the previous cycle.
REQ-009 q_valid  output  1  SHALL indicate that the queue head holds a valid instruction.
REQ-010 q_pc  output  30  SHALL be the word PC of the queue head.
REQ-011 q_insn  output  32  SHALL be the instruction word of the queue head.
REQ-012 stall  input  1  SHALL indicate that decode holds; the head SHALL NOT be consumed.
REQ-013 predict  input  1  SHALL be the decode branch-predict redirect strobe.
REQ-014 predict_target  input  30  SHALL be the predicted target word address.
REQ-015 correct  input  1  SHALL be the late branch-correction strobe.
REQ-016 correct_alt  input  30  SHALL be the corrected word address.

Function
REQ-017 The block SHALL keep a fetch PC, a circular queue of DEPTH {pc, insn} entries with head/tail pointers and an occupancy count, one in-flight flag with its PC, and one discard flag.
REQ-018 Issue: mem_re SHALL be 1 when (count + inflight) < DEPTH and neither predict nor correct is asserted; mem_addr SHALL equal the fetch PC.
REQ-019 A request SHALL be accepted when mem_re && mem_ready; the fetch PC SHALL then increment by 1 (wrapping mod 2^30), and inflight SHALL be set with the PC of the request.
REQ-020 Response: in the cycle after acceptance, mem_rdata SHALL be written at tail with the in-flight PC unless discard is set; inflight SHALL clear unless a new request is accepted in that same cycle.
REQ-021 Pop: the head SHALL advance when q_valid && !stall; q_valid SHALL equal count != 0; q_pc and q_insn SHALL come combinationally from the head entry.
REQ-022 A simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 count SHALL never exceed DEPTH; a request SHALL never be issued that could overflow the queue.
REQ-024 Redirect: on predict or correct, the queue SHALL be emptied (count=0, head=tail), and the fetch PC SHALL load the new address; correct SHALL take priority over predict when both are asserted.
REQ-025 On redirect with a request in flight, discard SHALL be set so that the returning word is dropped; discard SHALL clear when that response cycle passes.
REQ-026 On redirect, stall SHALL be ignored for that cycle; no pop SHALL occur.
REQ-027 Latency: a redirect in cycle N SHALL give a request to the new address in N+1, data in N+2, and q_valid=1 in N+3, with mem_ready=1 throughout.
REQ-028 With mem_ready=1 and no stall, the block SHALL sustain one instruction per cycle after the initial fill.
REQ-029 With mem_ready=0, mem_re and mem_addr SHALL hold their values, and the fetch PC SHALL NOT advance.

Reset
REQ-030 While rst_n=0: fetch PC=RESET_VEC, count=0, head=tail=0, inflight=0, discard=0, q_valid=0, mem_re=0.
REQ-031 Assertion of rst_n mid-operation SHALL clear the queue and in-flight state immediately; a response arriving after release SHALL be ignored.
REQ-032 The first request SHALL issue in the first cycle after rst_n rises, at mem_addr=RESET_VEC.

Verification
REQ-033 Reset release, RESET_VEC=0, mem_ready=1, memory returns rdata=address -> q_pc/q_insn sequence 0,1,2,3 with q_valid rising on cycle 2 after release.
REQ-034 DEPTH=4, stall held high for 10 cycles -> at most 4 entries, mem_re=0 once count+inflight=4, no entry lost or duplicated after stall release.
REQ-035 predict with predict_target=30'h37ab6fbb while a request is in flight -> in-flight word dropped, next q_pc=30'h37ab6fbb exactly 3 cycles later.
REQ-036 predict and correct asserted in the same cycle, correct_alt=30'h32bfaeaf -> fetch resumes at 30'h32bfaeaf; predict target never fetched.
REQ-037 mem_ready toggled 0/1 every other cycle -> mem_addr held stable while 0, q_pc strictly sequential, no gaps or repeats.
REQ-038 rst_n pulsed low for 1 cycle while the queue is full -> q_valid=0 immediately, fetch restarts at RESET_VEC.
